// File: rtl/stonyman_pkg.sv
// Shared constants, FSM encoding and pixel conditioning for the Stonyman row assembler.
// Optional build macro STONYMAN_PIXEL_INVERT_EN stores pixels inverted.
package stonyman_pkg;

    localparam int MAX_RESOLUTION = 112;
    localparam int PIXEL_WIDTH    = 8;
    localparam int ROW_BITS       = MAX_RESOLUTION * PIXEL_WIDTH;
    localparam int CNT_BITS       = 8;

    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(MAX_RESOLUTION - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PUBLISH = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Inversion makes a dark pupil look bright to the downstream detector.
    function automatic logic [PIXEL_WIDTH-1:0] condition_pixel(input logic [PIXEL_WIDTH-1:0] raw);
`ifdef STONYMAN_PIXEL_INVERT_EN
        return ~raw;
`else
        return raw;
`endif
    endfunction

endpackage

// File: rtl/stonyman_line_buffer.sv
// Working row register with per-column write and a publish copy onto the output row.
// Publish samples the pre-edge working row, so a same-cycle column-0 write belongs to the next row.
module stonyman_line_buffer
    import stonyman_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [CNT_BITS-1:0]    wr_col_i,
    input  logic [PIXEL_WIDTH-1:0] wr_data_i,
    input  logic                   publish_i,
    output logic [ROW_BITS-1:0]    row_o
);

    logic [ROW_BITS-1:0] work_q, work_d;
    logic [ROW_BITS-1:0] row_q, row_d;

    // Next working row and published row.
    always_comb begin
        work_d = work_q;
        for (int c = 0; c < MAX_RESOLUTION; c++) begin
            if (wr_en_i && (wr_col_i == CNT_BITS'(c))) begin
                work_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] = wr_data_i;
            end else begin
                work_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] = work_q[c*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
        if (publish_i) begin
            row_d = work_q;
        end else begin
            row_d = row_q;
        end
    end

    // Row storage registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            work_q <= '0;
            row_q  <= '0;
        end else begin
            work_q <= work_d;
            row_q  <= row_d;
        end
    end

    assign row_o = row_q;

endmodule

// File: rtl/stonyman_line_assembler.sv
// Assembles the serial Stonyman pixel stream into published rows and tracks frame boundaries.
// Build macro STONYMAN_PIXEL_INVERT_EN (see stonyman_pkg) selects inverted pixel storage.
module stonyman_line_assembler
    import stonyman_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   pixel_valid,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    output logic [ROW_BITS-1:0]    img_buf_newline,
    output logic                   line_valid,
    output logic [7:0]             row_index,
    output logic                   frame_capture_done,
    output logic                   overrun
);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] col_q, col_d;
    logic [CNT_BITS-1:0] row_q, row_d;
    logic [7:0]          row_index_q, row_index_d;
    logic                line_valid_q, line_valid_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic                accept_s;
    logic [CNT_BITS-1:0] accept_col_s;
    logic                wr_en_s;
    logic [CNT_BITS-1:0] wr_col_s;
    logic                publish_s;

    // Next-state, counter and output decode; frame_start overrides every state.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        row_index_d  = row_index_q;
        line_valid_d = 1'b0;
        overrun_d    = overrun_q;
        accept_s     = 1'b0;
        accept_col_s = col_q;
        publish_s    = 1'b0;

        if (frame_start) begin
            state_d      = ST_FILL;
            row_d        = '0;
            col_d        = '0;
            accept_s     = pixel_valid;
            accept_col_s = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (pixel_valid) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
                ST_FILL: begin
                    accept_s     = pixel_valid;
                    accept_col_s = col_q;
                end
                ST_PUBLISH: begin
                    publish_s    = 1'b1;
                    line_valid_d = 1'b1;
                    row_index_d  = row_q;
                    if (row_q == LAST_IDX) begin
                        // No next row to receive a pixel arriving here.
                        state_d = ST_DONE;
                        if (pixel_valid) begin
                            overrun_d = 1'b1;
                        end else begin
                            overrun_d = overrun_q;
                        end
                    end else begin
                        state_d      = ST_FILL;
                        row_d        = row_q + 8'd1;
                        col_d        = '0;
                        accept_s     = pixel_valid;
                        accept_col_s = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (accept_s) begin
            wr_en_s  = 1'b1;
            wr_col_s = accept_col_s;
            if (accept_col_s == LAST_IDX) begin
                state_d = ST_PUBLISH;
                col_d   = accept_col_s;
            end else begin
                col_d   = accept_col_s + 8'd1;
            end
        end else begin
            wr_en_s  = 1'b0;
            wr_col_s = accept_col_s;
        end

        // Leaving PUBLISH for DONE delays the rise by one cycle so it trails the last line_valid.
        done_d = ((state_d == ST_IDLE) || (state_d == ST_DONE)) && (state_q != ST_PUBLISH);
    end

    // FSM, counters and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            row_index_q  <= '0;
            line_valid_q <= 1'b0;
            done_q       <= 1'b1;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_index_q  <= row_index_d;
            line_valid_q <= line_valid_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    stonyman_line_buffer u_line_buffer (
        .clk_i     (clock),
        .rst_i     (reset),
        .wr_en_i   (wr_en_s),
        .wr_col_i  (wr_col_s),
        .wr_data_i (condition_pixel(pixel_data)),
        .publish_i (publish_s),
        .row_o     (img_buf_newline)
    );

    assign line_valid         = line_valid_q;
    assign row_index          = row_index_q;
    assign frame_capture_done = done_q;
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_stonyman_line_assembler.sv
// Directed and randomized bench for stonyman_line_assembler against a frame-level reference model.
module tb_stonyman_line_assembler;
    import stonyman_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   frame_start;
    logic                   pixel_valid;
    logic [PIXEL_WIDTH-1:0] pixel_data;
    logic [ROW_BITS-1:0]    img_buf_newline;
    logic                   line_valid;
    logic [7:0]             row_index;
    logic                   frame_capture_done;
    logic                   overrun;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a frame is being captured, a row is complete and awaits publishing, etc.
    bit                  m_capturing;
    bit                  m_pending;
    bit                  m_finished_now;
    int                  m_row;
    int                  m_col;
    int                  m_pend_row;
    logic [ROW_BITS-1:0] m_work;
    logic [ROW_BITS-1:0] m_bus;
    bit                  m_lv;
    int                  m_ri;
    bit                  m_done;
    bit                  m_ovr;

    stonyman_line_assembler dut (
        .clock              (clock),
        .reset              (reset),
        .frame_start        (frame_start),
        .pixel_valid        (pixel_valid),
        .pixel_data         (pixel_data),
        .img_buf_newline    (img_buf_newline),
        .line_valid         (line_valid),
        .row_index          (row_index),
        .frame_capture_done (frame_capture_done),
        .overrun            (overrun)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bus_sig(input logic [ROW_BITS-1:0] b);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < MAX_RESOLUTION; i++) begin
            s = {s[26:0], s[31:27]} ^ (32'(b[i*8 +: 8]) * 32'(i + 1));
        end
        return s;
    endfunction

    function automatic logic [7:0] stored_value(input logic [7:0] d);
`ifdef STONYMAN_PIXEL_INVERT_EN
        return 8'(255 - int'(d));
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_capturing    = 1'b0;
        m_pending      = 1'b0;
        m_finished_now = 1'b0;
        m_row          = 0;
        m_col          = 0;
        m_pend_row     = 0;
        m_work         = '0;
        m_bus          = '0;
        m_lv           = 1'b0;
        m_ri           = 0;
        m_done         = 1'b1;
        m_ovr          = 1'b0;
    endtask

    task automatic model_take(input logic [7:0] d);
        m_work[m_col*8 +: 8] = stored_value(d);
        m_col++;
        if (m_col == MAX_RESOLUTION) begin
            m_pending  = 1'b1;
            m_pend_row = m_row;
        end
    endtask

    task automatic model_step(input bit fs, input bit pv, input logic [7:0] d);
        m_lv           = 1'b0;
        m_finished_now = 1'b0;
        if (fs) begin
            m_pending   = 1'b0;
            m_capturing = 1'b1;
            m_row       = 0;
            m_col       = 0;
            if (pv) model_take(d);
        end else if (m_pending) begin
            m_pending = 1'b0;
            m_bus     = m_work;
            m_lv      = 1'b1;
            m_ri      = m_pend_row;
            if (m_pend_row == MAX_RESOLUTION - 1) begin
                m_capturing    = 1'b0;
                m_finished_now = 1'b1;
                if (pv) m_ovr = 1'b1;
            end else begin
                m_row = m_pend_row + 1;
                m_col = 0;
                if (pv) model_take(d);
            end
        end else if (m_capturing) begin
            if (pv) model_take(d);
        end else if (pv) begin
            m_ovr = 1'b1;
        end
        m_done = !m_capturing && !m_finished_now;
    endtask

    task automatic compare_all();
        check_val("line_valid", 32'(line_valid), 32'(m_lv));
        check_val("row_index", 32'(row_index), 32'(m_ri));
        check_val("frame_capture_done", 32'(frame_capture_done), 32'(m_done));
        check_val("overrun", 32'(overrun), 32'(m_ovr));
        check_val("bus_sig", bus_sig(img_buf_newline), bus_sig(m_bus));
        if (m_lv) begin
            for (int c = 0; c < MAX_RESOLUTION; c++) begin
                check_val($sformatf("byte%0d", c), 32'(img_buf_newline[c*8 +: 8]), 32'(m_bus[c*8 +: 8]));
            end
        end
    endtask

    task automatic cyc(input bit fs, input bit pv, input logic [7:0] d);
        frame_start = fs;
        pixel_valid = pv;
        pixel_data  = d;
        @(posedge clock);
        model_step(fs, pv, d);
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        reset       = 1'b1;
        #2;
        model_reset();
        compare_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] exp20;
        reset       = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = 8'h00;
        #12;
        model_reset();
        compare_all();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);

        // Full frame: row 0 is 0x7F, other rows carry their row number; continuous pixels.
        cyc(1'b1, 1'b0, 8'h00);
        for (int r = 0; r < MAX_RESOLUTION; r++) begin
            for (int c = 0; c < MAX_RESOLUTION; c++) begin
                cyc(1'b0, 1'b1, (r == 0) ? 8'h7F : 8'(r));
            end
        end
        repeat (3) cyc(1'b0, 1'b0, 8'h00);

        // Pixel after the frame is complete.
        cyc(1'b0, 1'b1, 8'h55);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);

        // Gapped row with value = column, then part of the next row.
        cyc(1'b1, 1'b0, 8'h00);
        for (int c = 0; c < MAX_RESOLUTION; c++) begin
            cyc(1'b0, 1'b1, 8'(c));
            cyc(1'b0, 1'b0, 8'hEE);
        end
`ifdef STONYMAN_PIXEL_INVERT_EN
        exp20 = 8'hDF;
`else
        exp20 = 8'h20;
`endif
        check_val("px20", 32'(img_buf_newline[32*8 +: 8]), 32'(exp20));
        for (int i = 0; i < 60; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));

        // Frame start with a pixel, three rows, 50 pixels of row 3, then abort.
        cyc(1'b1, 1'b1, 8'($urandom));
        for (int i = 1; i < 3 * MAX_RESOLUTION + 50; i++) cyc(1'b0, 1'b1, 8'($urandom));
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < MAX_RESOLUTION; i++) cyc(1'b0, 1'b1, 8'($urandom));
        repeat (3) cyc(1'b0, 1'b0, 8'h00);

        // Randomized traffic with occasional frame starts.
        for (int i = 0; i < 30000; i++) begin
            cyc(1'($urandom_range(0, 4999) == 0), 1'($urandom_range(0, 9) < 7), 8'($urandom));
        end

        // Reset in the middle of a frame.
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 200; i++) cyc(1'b0, 1'b1, 8'($urandom));
        apply_reset();
        repeat (4) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h20);
        for (int i = 1; i < MAX_RESOLUTION; i++) cyc(1'b0, 1'b1, 8'($urandom));
        repeat (3) cyc(1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stonyman_line_assembler.md
Name: stonyman_line_assembler

Overview:
Upstream feeder for the pupil detector. Collects the serial 8-bit pixel stream from the Stonyman ADC readout into full rows and publishes each completed row as a packed bus (img_buf_newline). Counts rows and drives frame_capture_done, so the detector sees a stable row once per line and a clear frame boundary.

Parameters:
MAX_RESOLUTION, 112, pixels per row and rows per frame (square sensor window)
PIXEL_WIDTH, 8, bits per pixel

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
frame_start  input  1  one-cycle pulse; begins a new frame at row 0, column 0
pixel_valid  input  1  pixel_data is valid this cycle (no backpressure; always accepted while a frame is active)
pixel_data  input  PIXEL_WIDTH  raw ADC pixel
img_buf_newline  output  MAX_RESOLUTION*PIXEL_WIDTH  last completed row; column c at bits [c*8+7 : c*8]
line_valid  output  1  one-cycle pulse when img_buf_newline updates
row_index  output  8  row number of the row currently on img_buf_newline
frame_capture_done  output  1  high when no frame is being captured
overrun  output  1  sticky error flag

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: img_buf_newline=0, line_valid=0, row_index=0, frame_capture_done=1, overrun=0, FSM=IDLE, column/row counters=0.
- FSM states: IDLE, FILL, PUBLISH, DONE.
  - IDLE: frame_capture_done=1. frame_start -> FILL; clears counters.
  - FILL: frame_capture_done=0. Each accepted pixel is written to the working buffer at column col; col increments. Accepting column MAX_RESOLUTION-1 -> PUBLISH.
  - PUBLISH (one cycle): working buffer copied to img_buf_newline; line_valid=1; row_index=row. If row==MAX_RESOLUTION-1 -> DONE, else row++, col=0 -> FILL.
  - DONE: frame_capture_done=1 (rises the cycle after the final PUBLISH). frame_start -> FILL with counters cleared.
- Latency: last pixel of a row accepted at edge N; img_buf_newline and line_valid are valid after edge N+1.
- Double buffered: img_buf_newline is held stable during the whole fill of the next row and changes only in PUBLISH.
- pixel_valid during PUBLISH: pixel is accepted as column 0 of the next row; no pixel is lost.
- pixel_valid in IDLE/DONE: pixel is dropped; overrun set. Only reset clears overrun.
- frame_start in FILL/PUBLISH: abort. The partial row is discarded and not published; row and col are cleared; FSM goes to FILL. overrun is unchanged.
- frame_start together with pixel_valid: the pixel is taken as row 0, column 0.
- Reset mid-frame: immediate return to reset values; no line_valid.
- Counters: col and row are 8 bits, and MAX_RESOLUTION must be 256 or less. Counters never wrap inside a frame.

Optional Feature:
Macro: STONYMAN_PIXEL_INVERT_EN.
- Defined: each pixel is stored as (2^PIXEL_WIDTH-1) - pixel_data, so a dark pupil appears bright to the detector.
- Undefined: pixels are stored unmodified.
- Timing and all control behaviour are identical in both builds.

Decomposition:
- Shared package stonyman_pkg holds MAX_RESOLUTION, PIXEL_WIDTH, the derived ROW_BITS = MAX_RESOLUTION*PIXEL_WIDTH, and the FSM state encoding (also used by the pupil detector bench).
- One sub-module, stonyman_line_buffer: the working row register with indexed pixel write and publish copy. It takes wr_en, wr_col, wr_data and publish, and outputs the row bus. The FSM and counters stay in the top module.

Test Plan:
- Reset, then frame_start plus 112 pixels of 0x7F with pixel_valid every cycle -> line_valid once, the edge after pixel 111; img_buf_newline = all 0x7F; row_index=0; frame_capture_done=0.
- Full frame: 112 rows of pixel value = row number -> 112 line_valid pulses, row_index 0..111 in order; frame_capture_done rises exactly one cycle after the last pulse.
- pixel_valid toggling 1/0 (gaps) within a row, pixel value = column -> byte c of img_buf_newline = c; line_valid only after the 112th valid pixel; bus unchanged during the following fill.
- frame_start after 50 pixels of row 3 -> no line_valid; the next 112 pixels publish with row_index=0.
- pixel_valid after DONE, value 0x55 -> overrun=1 and held; img_buf_newline unchanged; a following frame still works; only reset clears overrun.
- Build with STONYMAN_PIXEL_INVERT_EN and feed pixel 0x20 -> stored byte 0xDF; without the macro -> 0x20.
